// File: rtl/alu_system_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_system_control_unit
// Purpose  : Hardwired fetch/execute sequencer driving every ALUSystem control.
// Revision : 1.0 - initial release
// ============================================================================
module alu_system_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [15:0]      IROut,
    input  logic [3:0]       ALUOutFlag,
    output logic [1:0]       RF_OutASel,
    output logic [1:0]       RF_OutBSel,
    output logic [1:0]       RF_FunSel,
    output logic [3:0]       RF_RSel,
    output logic [3:0]       RF_TSel,
    output logic [3:0]       ALU_FunSel,
    output logic [1:0]       ARF_OutASel,
    output logic [1:0]       ARF_OutBSel,
    output logic [1:0]       ARF_FunSel,
    output logic [3:0]       ARF_RSel,
    output logic             IR_LH,
    output logic             IR_Enable,
    output logic [1:0]       IR_Funsel,
    output logic             Mem_WR,
    output logic             Mem_CS,
    output logic [1:0]       MuxASel,
    output logic [1:0]       MuxBSel,
    output logic             MuxCSel,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_FL   = 3'd1,
        S_FH   = 3'd2,
        S_EX   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [3:0] c_OP_LDI  = 4'h0;
    localparam logic [3:0] c_OP_LDM  = 4'h1;
    localparam logic [3:0] c_OP_STM  = 4'h2;
    localparam logic [3:0] c_OP_ALU  = 4'h3;
    localparam logic [3:0] c_OP_BRA  = 4'h4;
    localparam logic [3:0] c_OP_BNE  = 4'h5;
    localparam logic [3:0] c_OP_LDAR = 4'h6;
    localparam logic [3:0] c_OP_HALT = 4'h7;

    localparam logic [1:0] c_FUN_INC   = 2'b01;
    localparam logic [1:0] c_FUN_LOAD  = 2'b10;
    localparam logic [1:0] c_FUN_CLEAR = 2'b11;

    state_t           r_state_q;
    state_t           w_state_d;
    state_t           w_cur;
    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    logic [3:0] w_op;
    logic [1:0] w_d;
    logic [1:0] w_s;
    logic [3:0] w_f;
    logic [3:0] w_d_onehot;
    logic       w_unused_flags;

    assign w_op           = IROut[15:12];
    assign w_d            = IROut[11:10];
    assign w_s            = IROut[9:8];
    assign w_f            = IROut[7:4];
    assign w_d_onehot     = 4'b1000 >> w_d;
    assign w_unused_flags = ^ALUOutFlag[2:0];

    always_ff @(posedge Clock) begin
        r_state_q <= w_state_d;
        r_count_q <= w_count_d;
    end

    always_comb begin
        w_state_d = r_state_q;
        w_count_d = r_count_q;
        // While Reset is low the datapath sees only the clearing pattern.
        w_cur     = Reset ? r_state_q : S_RST;

        RF_OutASel  = 2'b00;
        RF_OutBSel  = 2'b00;
        RF_FunSel   = c_FUN_LOAD;
        RF_RSel     = 4'b0000;
        RF_TSel     = 4'b0000;
        ALU_FunSel  = 4'b0000;
        ARF_OutASel = 2'b00;
        ARF_OutBSel = 2'b00;
        ARF_FunSel  = c_FUN_LOAD;
        ARF_RSel    = 4'b0000;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = c_FUN_LOAD;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        halted      = 1'b0;

        if (!Reset) begin
            w_state_d = S_RST;
            w_count_d = '0;
        end else begin
            case (r_state_q)
                S_RST:   w_state_d = S_FL;
                S_FL:    w_state_d = S_FH;
                S_FH:    w_state_d = S_EX;
                S_EX: begin
                    w_count_d = r_count_q + CNT_W'(1);
                    w_state_d = (w_op == c_OP_HALT) ? S_HALT : S_FL;
                end
                S_HALT:  w_state_d = S_HALT;
                default: w_state_d = S_RST;
            endcase
        end

        case (w_cur)
            S_RST: begin
                RF_RSel    = 4'b1111;
                RF_TSel    = 4'b1111;
                RF_FunSel  = c_FUN_CLEAR;
                ARF_RSel   = 4'b1111;
                ARF_FunSel = c_FUN_CLEAR;
            end
            S_FL, S_FH: begin
                ARF_OutBSel = 2'b11;
                Mem_CS      = 1'b0;
                IR_Enable   = 1'b1;
                IR_LH       = (w_cur == S_FH);
                ARF_RSel    = 4'b0001;
                ARF_FunSel  = c_FUN_INC;
            end
            S_EX: begin
                case (w_op)
                    c_OP_LDI: begin
                        MuxASel = 2'b10;
                        RF_RSel = w_d_onehot;
                    end
                    c_OP_LDM: begin
                        Mem_CS  = 1'b0;
                        MuxASel = 2'b01;
                        RF_RSel = w_d_onehot;
                    end
                    c_OP_STM: begin
                        RF_OutASel = w_d;
                        Mem_CS     = 1'b0;
                        Mem_WR     = 1'b1;
                    end
                    c_OP_ALU: begin
                        RF_OutASel = w_d;
                        RF_OutBSel = w_s;
                        ALU_FunSel = w_f;
                        RF_RSel    = w_d_onehot;
                    end
                    c_OP_BRA: begin
                        MuxBSel  = 2'b10;
                        ARF_RSel = 4'b0001;
                    end
                    c_OP_BNE: begin
                        // Branch taken only when the Z flag is clear.
                        if (!ALUOutFlag[3]) begin
                            MuxBSel  = 2'b10;
                            ARF_RSel = 4'b0001;
                        end
                    end
                    c_OP_LDAR: begin
                        MuxBSel  = 2'b10;
                        ARF_RSel = 4'b1000;
                    end
                    default: ;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state       = r_state_q;
    assign instr_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_system_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_system_control_unit
// Purpose  : Control unit driving a behavioural ALUSystem, scored against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_system_control_unit;

    localparam int CNT_W = 16;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic [15:0]      IROut;
    logic [3:0]       ALUOutFlag;
    logic [1:0]       RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]       RF_RSel, RF_TSel, ALU_FunSel;
    logic [1:0]       ARF_OutASel, ARF_OutBSel, ARF_FunSel;
    logic [3:0]       ARF_RSel;
    logic             IR_LH, IR_Enable;
    logic [1:0]       IR_Funsel;
    logic             Mem_WR, Mem_CS;
    logic [1:0]       MuxASel, MuxBSel;
    logic             MuxCSel;
    logic [2:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    always #5 Clock = ~Clock;

    alu_system_control_unit #(.CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RSel(ARF_RSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .state(state), .halted(halted), .instr_count(instr_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'h0:    return a;
            4'h1:    return b;
            4'h2:    return ~a;
            4'h3:    return ~b;
            4'h4:    return a + b;
            4'h5:    return a - b;
            4'h6:    return a & b;
            4'h7:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [7:0] mux4(input logic [1:0] s, input logic [7:0] i0, input logic [7:0] i1,
                                        input logic [7:0] i2, input logic [7:0] i3);
        case (s)
            2'd0:    return i0;
            2'd1:    return i1;
            2'd2:    return i2;
            default: return i3;
        endcase
    endfunction

    function automatic logic [7:0] reg_fun(input logic [1:0] fs, input logic [7:0] cur, input logic [7:0] din);
        case (fs)
            2'b00:   return cur - 8'd1;
            2'b01:   return cur + 8'd1;
            2'b10:   return din;
            default: return 8'd0;
        endcase
    endfunction

    // ---------------- behavioural ALUSystem datapath ----------------
    logic [7:0]  rf   [4];     // R1..R4
    logic [7:0]  arf  [4];     // AR, SP, PCpast, PC
    logic [7:0]  mem  [256];
    logic [7:0]  img  [256];   // program image, copied into mem while Reset is low
    logic [15:0] ir;
    logic [3:0]  flags;
    logic [7:0]  w_aout, w_bout, w_cout, w_dout, w_alu_a, w_aluout, w_memout, w_mux_a, w_mux_b;

    always_comb begin
        w_aout   = rf[RF_OutASel];
        w_bout   = rf[RF_OutBSel];
        w_cout   = arf[ARF_OutASel];
        w_dout   = arf[ARF_OutBSel];
        w_alu_a  = MuxCSel ? w_cout : w_aout;
        w_aluout = alu_f(ALU_FunSel, w_alu_a, w_bout);
        w_memout = mem[w_dout];
        w_mux_a  = mux4(MuxASel, w_aluout, w_memout, ir[7:0], w_cout);
        w_mux_b  = mux4(MuxBSel, w_aluout, w_memout, ir[7:0], w_cout);
    end

    assign IROut      = ir;
    assign ALUOutFlag = flags;

    always @(posedge Clock) begin
        if (!Mem_CS && Mem_WR) mem[w_dout] <= w_aluout;
        for (int i = 0; i < 4; i++) begin
            if (RF_RSel[3-i])  rf[i]  <= reg_fun(RF_FunSel, rf[i], w_mux_a);
            if (ARF_RSel[3-i]) arf[i] <= reg_fun(ARF_FunSel, arf[i], w_mux_b);
        end
        if (IR_Enable) begin
            case (IR_Funsel)
                2'b10:   if (IR_LH) ir[15:8] <= w_memout; else ir[7:0] <= w_memout;
                2'b11:   ir <= 16'h0;
                2'b01:   ir <= ir + 16'd1;
                default: ir <= ir - 16'd1;
            endcase
        end
        if (!Reset) begin
            flags <= 4'h0;
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (RF_FunSel == 2'b10 && MuxASel == 2'b00 && RF_RSel != 4'b0000) begin
            flags <= {w_aluout == 8'd0, 1'b0, w_aluout[7], 1'b0};
        end
    end

    // ---------------- instruction-level reference model ----------------
    typedef struct packed {
        logic [15:0] instr;
        logic [3:0]  rf_rsel;
        logic [3:0]  arf_rsel;
        logic [1:0]  outa;
        logic [1:0]  outb;
        logic        mem_wr;
        logic        mem_cs;
        logic [15:0] cnt;
        logic [7:0]  pc;
        logic [7:0]  ar;
        logic [31:0] regs;
        logic        st;
        logic [7:0]  st_addr;
        logic [7:0]  st_val;
        logic        halt;
    } exp_t;

    exp_t       sb[$];
    exp_t       pend;
    logic       post_pending = 1'b0;
    logic       mon_en = 1'b0;

    logic [7:0] iso_r   [4];
    logic [7:0] iso_mem [256];
    logic [7:0] iso_pc, iso_ar;
    logic       iso_z;

    function automatic logic [3:0] rf_onehot(input logic [1:0] d);
        case (d)
            2'd0:    return 4'b1000;
            2'd1:    return 4'b0100;
            2'd2:    return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic isa_build(input int n_max, output int n_out, output logic hit_halt);
        exp_t        e;
        logic [15:0] ins;
        logic [3:0]  op;
        logic [1:0]  d, s;
        logic [7:0]  imm, res;
        logic        taken;
        for (int i = 0; i < 4; i++) iso_r[i] = 8'd0;
        for (int i = 0; i < 256; i++) iso_mem[i] = img[i];
        iso_pc = 8'd0; iso_ar = 8'd0; iso_z = 1'b0;
        hit_halt = 1'b0; n_out = 0;
        for (int k = 0; k < n_max && !hit_halt; k++) begin
            ins   = {iso_mem[8'(iso_pc + 8'd1)], iso_mem[iso_pc]};
            op    = ins[15:12]; d = ins[11:10]; s = ins[9:8]; imm = ins[7:0];
            taken = (op == 4'h4) || (op == 4'h5 && !iso_z);
            e          = '0;
            e.instr    = ins;
            e.rf_rsel  = (op == 4'h0 || op == 4'h1 || op == 4'h3) ? rf_onehot(d) : 4'b0000;
            e.arf_rsel = taken ? 4'b0001 : (op == 4'h6) ? 4'b1000 : 4'b0000;
            e.outa     = (op == 4'h2 || op == 4'h3) ? d : 2'd0;
            e.outb     = (op == 4'h3) ? s : 2'd0;
            e.mem_wr   = (op == 4'h2);
            e.mem_cs   = !(op == 4'h1 || op == 4'h2);
            e.cnt      = 16'(k);
            iso_pc     = iso_pc + 8'd2;
            case (op)
                4'h0: iso_r[d] = imm;
                4'h1: iso_r[d] = iso_mem[iso_ar];
                4'h2: begin
                    iso_mem[iso_ar] = iso_r[d];
                    e.st = 1'b1; e.st_addr = iso_ar; e.st_val = iso_r[d];
                end
                4'h3: begin
                    res = alu_f(imm[7:4], iso_r[d], iso_r[s]);
                    iso_r[d] = res;
                    iso_z = (res == 8'd0);
                end
                4'h6: iso_ar = imm;
                default: ;
            endcase
            if (taken) iso_pc = imm;
            e.pc   = iso_pc;
            e.ar   = iso_ar;
            e.regs = {iso_r[0], iso_r[1], iso_r[2], iso_r[3]};
            e.halt = (op == 4'h7);
            sb.push_back(e);
            n_out++;
            if (op == 4'h7) hit_halt = 1'b1;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clock) begin
        if (mon_en) begin
            if (post_pending) begin
                post_pending = 1'b0;
                chk("post_pc",   {24'd0, arf[3]}, {24'd0, pend.pc});
                chk("post_ar",   {24'd0, arf[0]}, {24'd0, pend.ar});
                chk("post_regs", {rf[0], rf[1], rf[2], rf[3]}, pend.regs);
                chk("post_state", {29'd0, state}, pend.halt ? 32'd4 : 32'd1);
                if (pend.st) chk("post_mem", {24'd0, mem[pend.st_addr]}, {24'd0, pend.st_val});
            end
            if (Reset && state == 3'd3) begin
                if (sb.size() == 0) begin
                    chk("ex_unexpected", {16'd0, IROut}, 32'hFFFF_FFFF);
                end else begin
                    pend = sb.pop_front();
                    chk("ex_instr",    {16'd0, IROut},      {16'd0, pend.instr});
                    chk("ex_rf_rsel",  {28'd0, RF_RSel},    {28'd0, pend.rf_rsel});
                    chk("ex_arf_rsel", {28'd0, ARF_RSel},   {28'd0, pend.arf_rsel});
                    chk("ex_outa",     {30'd0, RF_OutASel}, {30'd0, pend.outa});
                    chk("ex_outb",     {30'd0, RF_OutBSel}, {30'd0, pend.outb});
                    chk("ex_mem_wr",   {31'd0, Mem_WR},     {31'd0, pend.mem_wr});
                    chk("ex_mem_cs",   {31'd0, Mem_CS},     {31'd0, pend.mem_cs});
                    chk("ex_count",    {16'd0, instr_count}, {16'd0, pend.cnt});
                    post_pending = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [7:0] a, input logic [15:0] ins);
        img[a]             = ins[7:0];
        img[8'(a + 8'd1)]  = ins[15:8];
    endtask

    task automatic run_prog(input int n_max, output logic hit_halt, output int n_ins);
        int budget;
        mon_en = 1'b0;
        @(negedge Clock); #2 Reset = 1'b0;
        #1 chk("rst_memcs_now", {31'd0, Mem_CS}, 32'd1);
        repeat (2) @(negedge Clock);
        #1;
        chk("rst_state",  {29'd0, state}, 32'd0);
        chk("rst_count",  {16'd0, instr_count}, 32'd0);
        chk("rst_memwr",  {31'd0, Mem_WR}, 32'd0);
        isa_build(n_max, n_ins, hit_halt);
        mon_en = 1'b1;
        #1 Reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clock); #1;
            chk("latency_state", {29'd0, state}, 32'(k));
        end
        budget = 3 * n_max + 10;
        while (budget > 0 && (sb.size() != 0 || post_pending)) begin
            @(negedge Clock); #1;
            budget--;
        end
        if (budget == 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
            post_pending = 1'b0;
        end
        mon_en = 1'b0;
    endtask

    task automatic halt_hold(input int n_ins);
        repeat (20) begin
            @(negedge Clock); #1;
            chk("halt_flag",  {31'd0, halted}, 32'd1);
            chk("halt_state", {29'd0, state}, 32'd4);
            chk("halt_count", {16'd0, instr_count}, 32'(n_ins));
        end
    endtask

    task automatic reset_mid_fh();
        int budget;
        mon_en = 1'b0;
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        @(negedge Clock); #2 Reset = 1'b0;
        @(negedge Clock); #2 Reset = 1'b1;
        budget = 12;
        do begin
            @(negedge Clock); #1;
            budget--;
        end while (state != 3'd2 && budget > 0);
        chk("fh_reached", {29'd0, state}, 32'd2);
        #1 Reset = 1'b0;
        #1;
        chk("fh_rst_memcs", {31'd0, Mem_CS}, 32'd1);
        chk("fh_rst_iren",  {31'd0, IR_Enable}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge Clock); #1;
            chk("fh_rst_state", {29'd0, state}, 32'd0);
            chk("fh_rst_cs",    {31'd0, Mem_CS}, 32'd1);
        end
        chk("fh_rst_pc",    {24'd0, arf[3]}, 32'd0);
        chk("fh_rst_regs",  {rf[0], rf[1], rf[2], rf[3]}, 32'd0);
        chk("fh_rst_count", {16'd0, instr_count}, 32'd0);
        #1 Reset = 1'b1;
        @(negedge Clock); #1;
        chk("fh_rel_state", {29'd0, state}, 32'd1);
    endtask

    initial begin
        logic h;
        int   n;
        logic [3:0] op;

        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        reset_mid_fh();

        // LDI R2,0x5A then two NOPs and HALT at PC 6
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        put(8'h00, 16'h045A); put(8'h02, 16'h8000); put(8'h04, 16'hF123); put(8'h06, 16'h7000);
        run_prog(20, h, n);
        if (h) halt_hold(n);

        // arithmetic, then store/load through AR
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        put(8'h00, 16'h0003); put(8'h02, 16'h0404); put(8'h04, 16'h3140);
        put(8'h06, 16'h6020); put(8'h08, 16'h2000); put(8'h0A, 16'h1800); put(8'h0C, 16'h7000);
        run_prog(20, h, n);

        // BNE with Z set (falls through) and with Z clear (taken to 0x10)
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        put(8'h00, 16'h0005); put(8'h02, 16'h0405); put(8'h04, 16'h3150); put(8'h06, 16'h5010);
        put(8'h08, 16'h3140); put(8'h0A, 16'h5010); put(8'h0C, 16'h0CEE); put(8'h0E, 16'h7000);
        put(8'h10, 16'h7000);
        run_prog(20, h, n);

        for (int p = 0; p < 8; p++) begin
            for (int a = 0; a < 256; a += 2) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'h7 && ($urandom % 4) != 0) op = 4'h8;
                img[a]     = 8'($urandom);
                img[a + 1] = {op, 4'($urandom)};
            end
            run_prog(40, h, n);
            if (h) halt_hold(n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
